// File: rtl/spart_pkg.sv
// Shared definitions for the SPART bus controller: register addresses,
// configuration-state encoding and a status-byte helper.
package spart_pkg;

    localparam int DIV_W_DEF = 16;

    localparam logic [1:0] ADDR_DATA = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DBLO = 2'b10;
    localparam logic [1:0] ADDR_DBHI = 2'b11;

    // PEND_HI_RUN is "waiting for the high byte while the old divisor keeps ticking"
    typedef enum logic [1:0] {
        CFG_IDLE        = 2'b00,
        CFG_PEND_HI     = 2'b01,
        CFG_RUN         = 2'b10,
        CFG_PEND_HI_RUN = 2'b11
    } cfg_state_t;

    function automatic logic [7:0] status_byte(input logic tbr, input logic rda);
        return {6'b000000, tbr, rda};
    endfunction

endpackage

// File: rtl/spart_baud_gen.sv
// Baud tick generator: emits a registered one-cycle Enable every div cycles
// while run is high; load restarts the count so the next edge ticks.
module spart_baud_gen
    import spart_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             run,
    input  logic             load,
    output logic             Enable
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;
    logic             enable_q;
    logic             enable_d;

    // Down-counter next state; divisors 0 and 1 both reload to 0 (tick every cycle)
    always_comb begin
        cnt_d    = cnt_q;
        enable_d = 1'b0;
        if (run) begin
            if (cnt_q == {DIV_W{1'b0}}) begin
                enable_d = 1'b1;
                cnt_d    = (div <= DIV_W'(1)) ? {DIV_W{1'b0}} : (div - DIV_W'(1));
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end else begin
            cnt_d = {DIV_W{1'b0}};
        end
        // A commit on the same edge as a tick restarts the count but keeps the tick
        if (load) begin
            cnt_d = {DIV_W{1'b0}};
        end else begin
            cnt_d = cnt_d;
        end
    end

    // Counter and tick registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= {DIV_W{1'b0}};
            enable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            enable_q <= enable_d;
        end
    end

    assign Enable = enable_q;

endmodule

// File: rtl/spart_bus_ctrl.sv
// SPART bus-side controller: register decode, read-data steering, TX/RX strobes
// and the divisor configuration FSM feeding the baud generator.
module spart_bus_ctrl
    import spart_pkg::*;
#(
    parameter int               DIV_W     = DIV_W_DEF,
    parameter logic [DIV_W-1:0] RESET_DIV = '0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       IOCS,
    input  logic       IORW,
    input  logic [1:0] IOADDR,
    input  logic [7:0] DATABUS_IN,
    output logic [7:0] DATABUS_OUT,
    output logic       DATABUS_OE,
    input  logic [7:0] RX_DATA,
    input  logic       RDA,
    input  logic       TBR,
    output logic [7:0] TX_DATA,
    output logic       TX_LOAD,
    output logic       RX_READ,
    output logic       Enable
);

    localparam cfg_state_t RST_STATE = (RESET_DIV == '0) ? CFG_IDLE : CFG_RUN;

    cfg_state_t       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       div_lo_q, div_lo_d;
    logic [7:0]       tx_data_q, tx_data_d;

    logic        acc_rd_s, acc_wr_s;
    logic        wr_data_s, wr_dblo_s, wr_dbhi_s, rd_data_s;
    logic        run_s;
    logic [15:0] div_rd_s;
    logic [7:0]  rd_bus_s;

    assign acc_rd_s  = IOCS & IORW;
    assign acc_wr_s  = IOCS & ~IORW;
    assign wr_data_s = acc_wr_s & (IOADDR == ADDR_DATA);
    assign wr_dblo_s = acc_wr_s & (IOADDR == ADDR_DBLO);
    assign wr_dbhi_s = acc_wr_s & (IOADDR == ADDR_DBHI);
    assign rd_data_s = acc_rd_s & (IOADDR == ADDR_DATA);
    assign div_rd_s  = 16'(div_q);
    assign run_s     = (state_q == CFG_RUN) | (state_q == CFG_PEND_HI_RUN);

    // Read-data steering; the bus idles at zero when not being read
    always_comb begin
        rd_bus_s = 8'h00;
        if (acc_rd_s) begin
            case (IOADDR)
                ADDR_DATA: rd_bus_s = RX_DATA;
                ADDR_STAT: rd_bus_s = status_byte(TBR, RDA);
                ADDR_DBLO: rd_bus_s = div_rd_s[7:0];
                ADDR_DBHI: rd_bus_s = div_rd_s[15:8];
                default:   rd_bus_s = 8'h00;
            endcase
        end else begin
            rd_bus_s = 8'h00;
        end
    end

    // Config FSM and register next-state; the full divisor only changes on the high-byte write
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        div_lo_d  = div_lo_q;
        tx_data_d = tx_data_q;
        if (wr_data_s) begin
            tx_data_d = DATABUS_IN;
        end else begin
            tx_data_d = tx_data_q;
        end
        if (wr_dblo_s) begin
            div_lo_d = DATABUS_IN;
            case (state_q)
                CFG_IDLE, CFG_PEND_HI:       state_d = CFG_PEND_HI;
                CFG_RUN, CFG_PEND_HI_RUN:    state_d = CFG_PEND_HI_RUN;
                default:                     state_d = CFG_IDLE;
            endcase
        end else if (wr_dbhi_s) begin
            div_d   = DIV_W'({DATABUS_IN, div_lo_q});
            state_d = CFG_RUN;
        end else begin
            state_d = state_q;
        end
    end

    // Configuration and transmit-data registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RST_STATE;
            div_q     <= RESET_DIV;
            div_lo_q  <= 8'h00;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            div_lo_q  <= div_lo_d;
            tx_data_q <= tx_data_d;
        end
    end

    spart_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk    (clk),
        .rst    (rst),
        .div    (div_q),
        .run    (run_s),
        .load   (wr_dbhi_s),
        .Enable (Enable)
    );

    assign DATABUS_OUT = rd_bus_s;
    assign DATABUS_OE  = acc_rd_s;
    assign TX_DATA     = tx_data_q;
    assign TX_LOAD     = rst & wr_data_s;
    assign RX_READ     = rst & rd_data_s;

endmodule
